decoder_arbiter: RTL

DECODER_ARBITER -- requirements
Module: decoder_arbiter

---
 rtl/decoder_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/decoder_arbiter.sv
// rtl/decoder_arbiter.sv - round-robin arbiter owning a shared 3-to-8 decoder
//
// Eight requesters compete for one decoder. The winner's index drives the
// select lines {A,B,C}; en and the one-hot gnt are held for the whole grant.
// Every grant is followed by a RELEASE cycle and then a fresh IDLE
// arbitration, so two consecutive grants are always separated by two
// cycles with en low. The search pointer moves to winner+1 on each release.
//
// Build option: define ARB_TIMEOUT_EN to add the forced-release counter.
// Without it, the timeout port is tied low and no counter exists.
//
// Ports:
//   clk      clock, rising edge
//   rst_n    asynchronous active-low reset
//   req[7:0] request vector, bit i = requester i
//   done     release strobe from the current owner (used only in GRANT)
//   en       decoder enable, high while a grant is held
//   A,B,C    decoder select sel[2], sel[1], sel[0]
//   gnt[7:0] one-hot grant, gnt[{A,B,C}] = en
//   busy     state is not IDLE
//   timeout  one-cycle pulse on a forced release
module decoder_arbiter #(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic       done,
   output logic       en,
   output logic       A,
   output logic       B,
   output logic       C,
   output logic [7:0] gnt,
   output logic       busy,
   output logic       timeout
);

   if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
      $error("decoder_arbiter: TIMEOUT must be in 2..255");
   end

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   state_t     state, state_nx;
   logic [2:0] sel, sel_nx;
   logic [2:0] ptr, ptr_nx;
   logic       en_nx;
   logic [7:0] gnt_nx;
   logic [2:0] winner;
   logic [2:0] idx;
   logic       found;
   logic       release_now;

`ifdef ARB_TIMEOUT_EN
   logic [7:0] tcnt;
   logic       timeout_nx;
   logic       timeout_q;
`endif

   // Scan offsets from the top down so the smallest offset from ptr
   // (the first set bit going upward with wrap) is the last to win.
   always_comb begin
      winner = ptr;
      found  = 1'b0;
      idx    = ptr;
      for (int i = 7; i >= 0; i--) begin
         idx = ptr + 3'(i);
         if (req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      state_nx    = state;
      sel_nx      = sel;
      en_nx       = en;
      gnt_nx      = gnt;
      ptr_nx      = ptr;
      release_now = 1'b0;
`ifdef ARB_TIMEOUT_EN
      timeout_nx  = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (found) begin
               state_nx = GRANT;
               sel_nx   = winner;
               en_nx    = 1'b1;
               gnt_nx   = 8'd1 << winner;
            end
         end
         GRANT: begin
            // Only the owner's own request bit matters here.
            release_now = done || !req[sel];
`ifdef ARB_TIMEOUT_EN
            // Pulses even when done arrives on the same edge.
            if (tcnt == 8'(TIMEOUT - 1)) begin
               release_now = 1'b1;
               timeout_nx  = 1'b1;
            end
`endif
            if (release_now) begin
               state_nx = RELEASE;
               en_nx    = 1'b0;
               gnt_nx   = 8'd0;
            end
         end
         RELEASE: begin
            state_nx = IDLE;
            ptr_nx   = sel + 3'd1;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sel   <= 3'd0;
         ptr   <= 3'd0;
         en    <= 1'b0;
         gnt   <= 8'd0;
         busy  <= 1'b0;
      end else begin
         state <= state_nx;
         sel   <= sel_nx;
         ptr   <= ptr_nx;
         en    <= en_nx;
         gnt   <= gnt_nx;
         busy  <= (state_nx != IDLE);
      end
   end

`ifdef ARB_TIMEOUT_EN
   // Counter is zero on the first GRANT cycle and counts GRANT cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tcnt      <= 8'd0;
         timeout_q <= 1'b0;
      end else begin
         tcnt      <= (state == GRANT && state_nx == GRANT) ? tcnt + 8'd1 : 8'd0;
         timeout_q <= timeout_nx;
      end
   end

   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   assign A = sel[2];
   assign B = sel[1];
   assign C = sel[0];

endmodule
